if_id_buf: RTL
==============

# if_id_buf

Parametrised IF/ID boundary buffer replacing the single-entry IF/ID flop: a DEPTH-entry FIFO of (pc, instruction) pairs between fetch and decode. Fetch pushes with a valid/ready handshake, decode pops with its own ready, and a flush empties the buffer in one cycle. Hold (decode stalled) and flush (control hazard) are distinct, so instructions already fetched are kept during a data stall instead of being dropped. When empty, decode sees a configurable bubble instruction.

## Interface
- DATA_W, 32, instruction width
- ADDR_W, 32, pc width
- DEPTH, 2, entry count; power of two, ≥2
- BUBBLE_INST, 32'h00000013, instruction presented when empty (addi x0,x0,0)
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- flush  in  1  discard all entries (branch/jump taken)
- in_valid  in  1  fetch offers an entry
- in_pc  in  ADDR_W  pc of offered instruction
- in_inst  in  DATA_W  offered instruction
- in_ready  out  1  buffer accepts this cycle
- out_valid  out  1  head entry valid
- out_pc  out  ADDR_W  head pc, 0 when empty
- out_inst  out  DATA_W  head instruction, BUBBLE_INST when empty
- out_ready  in  1  decode consumes head (deasserted on data stall)

## Operation
- State: DEPTH entry regs, wr_ptr/rd_ptr of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
- push = in_valid && in_ready && !flush; pop = out_valid && out_ready && !flush.
- in_ready = (count != DEPTH); independent of out_ready (no pass-through when full).
- out_valid = (count != 0); out_pc/out_inst = entry[rd_ptr] when valid, else 0 / BUBBLE_INST.
- push only: write entry[wr_ptr], wr_ptr+1, count+1. pop only: rd_ptr+1, count−1. Both: both pointers advance, count unchanged (legal at empty? no: pop requires count≠0).
- flush: count←0, wr_ptr←0, rd_ptr←0; flush overrides any simultaneous push/pop. Entry contents need not be cleared.
- Order preserved: entries leave in push order.
- rst: count, pointers, all entries ← 0; outputs immediately show empty (out_valid 0, out_pc 0, out_inst BUBBLE_INST, in_ready 1).

## Timing
- Push at edge k → visible on out_* after edge k (1-cycle latency, same as old IF/ID flop).
- in_ready, out_valid, out_* are functions of registered state only (no in_* → out_* or out_ready → in_ready combinational path).
- Full (count=DEPTH): in_ready 0 that cycle even if out_ready 1; reasserts the cycle after a pop.
- Empty with out_ready 1: no pop, count stays 0.
- Flush asserted with in_valid: offered entry dropped; buffer empty next cycle; fetch must re-present from new pc.
- Reset mid-stream: async clear regardless of clk; first push accepted on first edge after rst falls.

## Configuration
- IF_ID_BUF_PERF_EN defined: adds outputs perf_stall_cnt [31:0] (cycles with out_valid && !out_ready && !flush) and perf_flush_cnt [15:0] (cycles with flush && count≠0); both saturate at all-ones, clear on rst only.
- Not defined: ports and counters absent; core behaviour identical.

## Test plan
- Reset: rst high mid-clock → out_valid 0, out_inst 32'h00000013, out_pc 0, in_ready 1 without waiting for edge.
- Streaming: out_ready 1, push pc 0x0,0x4,0x8 on consecutive cycles → appear on out_pc one cycle later each, count never exceeds 1.
- Hold: out_ready 0, push 0x10,0x14 → in_ready 0 after second; third offer 0x18 not accepted; release out_ready → 0x10,0x14 in order, then 0x18 after re-offer.
- Flush: buffer holding 2 entries, flush with in_valid (pc 0x40) → next cycle out_valid 0, count 0, 0x40 not stored.
- Wrap: DEPTH=4, 10 push/pop cycles with random out_ready → output sequence equals input sequence, pointers wrap without loss.
- Perf (IF_ID_BUF_PERF_EN): 5 stalled cycles with valid head, 2 flushes of non-empty buffer → perf_stall_cnt 5, perf_flush_cnt 2.

Source files
------------

// File: rtl/if_id_buf_if.sv
// Fetch/decode handshake bundle for the IF/ID buffer.
// master = testbench or fetch/decode side, slave = the buffer.
interface if_id_buf_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic [ADDR_W-1:0] in_pc;
  logic [DATA_W-1:0] in_inst;
  logic              in_ready;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_inst;
  logic              out_ready;

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/if_id_buf.sv
// DEPTH-entry (pc, instruction) FIFO at the IF/ID boundary; shows a bubble when empty.
// Optional stall/flush performance counters are enabled by defining IF_ID_BUF_PERF_EN.
module if_id_buf #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH       = 2,
  parameter logic [DATA_W-1:0] BUBBLE_INST = DATA_W'(32'h0000_0013)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
`ifdef IF_ID_BUF_PERF_EN
  output logic [31:0]  perf_stall_cnt,
  output logic [15:0]  perf_flush_cnt,
`endif
  if_id_buf_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic              push;
  logic              pop;

  // Handshake and head view depend only on registered state.
  assign bus.in_ready  = (count != CNT_W'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign bus.out_pc    = bus.out_valid ? pc_mem[rd_ptr]   : '0;
  assign bus.out_inst  = bus.out_valid ? inst_mem[rd_ptr] : BUBBLE_INST;

  assign push = bus.in_valid  && bus.in_ready  && !flush;
  assign pop  = bus.out_valid && bus.out_ready && !flush;

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= bus.in_pc;
        inst_mem[wr_ptr] <= bus.in_inst;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

`ifdef IF_ID_BUF_PERF_EN
  // Saturating counters: decode stall cycles and flushes that discarded work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (bus.out_valid && !bus.out_ready && !flush && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (flush && (count != '0) && (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
      end
    end
  end
`endif
endmodule
